// File: rtl/performance_way_latency_monitor_pkg.sv
// Shared definitions for the per-way latency monitor: window FSM state
// encodings and the default widths used by the top, the timer and the bus interface.
// No logic lives here.
package performance_way_latency_monitor_pkg;

  localparam int DEF_WAY    = 4;
  localparam int DEF_LAT_WD = 20;
  localparam int DEF_REQ_WD = 12;
  localparam int DEF_SUM_WD = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FULL  = 2'd2,
    ST_CLEAR = 2'd3
  } perf_state_e;

endpackage

// File: rtl/performance_way_latency_monitor_if.sv
// Purpose : host/op-event side bus of the latency monitor (config, op pulses, results).
// Latency : n/a (wires only).
// Backpressure: none; op pulses and the copy-done pulse are always accepted.
// master = event source / host, slave = the monitor.
interface performance_way_latency_monitor_if
  import performance_way_latency_monitor_pkg::*;
#(
  parameter int WAY    = DEF_WAY,
  parameter int LAT_WD = DEF_LAT_WD,
  parameter int REQ_WD = DEF_REQ_WD,
  parameter int SUM_WD = DEF_SUM_WD
);
  logic [REQ_WD-1:0] i_cfg_thresh;
  logic              i_cp_cmplt;
  logic [WAY-1:0]    i_op_start;
  logic [WAY-1:0]    i_op_end;
  logic [WAY-1:0]    i_op_fail;
  logic [SUM_WD-1:0] o_lat_sum;
  logic [REQ_WD-1:0] o_req_cnt;
  logic [REQ_WD-1:0] o_fail_cnt;
  logic              o_ready;
  logic [LAT_WD-1:0] o_lat_max;
  logic [LAT_WD-1:0] o_lat_min;

  modport master (
    output i_cfg_thresh, i_cp_cmplt, i_op_start, i_op_end, i_op_fail,
    input  o_lat_sum, o_req_cnt, o_fail_cnt, o_ready, o_lat_max, o_lat_min
  );

  modport slave (
    input  i_cfg_thresh, i_cp_cmplt, i_op_start, i_op_end, i_op_fail,
    output o_lat_sum, o_req_cnt, o_fail_cnt, o_ready, o_lat_max, o_lat_min
  );
endinterface

// File: rtl/performance_way_latency_monitor_timer.sv
// Purpose : one way's op timer; counts cycles from start pulse to end pulse.
// Latency : done/fail/lat are combinational in the end cycle (lat = cycles since start).
// Backpressure: none; every pulse is taken, an end on an idle way is ignored.
// Ports: i_bus_clk/i_bus_rst_n clock and async active-low reset; i_start/i_end/i_fail
// per-way pulses; o_done completion strobe, o_fail its fail qualifier, o_lat its latency.
module performance_way_latency_monitor_timer
  import performance_way_latency_monitor_pkg::*;
#(
  parameter int LAT_WD = DEF_LAT_WD
) (
  input  logic              i_bus_clk,
  input  logic              i_bus_rst_n,
  input  logic              i_start,
  input  logic              i_end,
  input  logic              i_fail,
  output logic              o_done,
  output logic              o_fail,
  output logic [LAT_WD-1:0] o_lat
);

  localparam logic [LAT_WD-1:0] LAT_MAX = {LAT_WD{1'b1}};

  logic              busy_q, busy_d;
  logic [LAT_WD-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (i_start) begin
      // A start always (re)arms the timer; a simultaneous end on a busy way
      // still completes the old op through o_done below.
      busy_d = 1'b1;
      cnt_d  = {{(LAT_WD-1){1'b0}}, 1'b1};
    end else if (i_end && busy_q) begin
      busy_d = 1'b0;
    end else if (busy_q && (cnt_q != LAT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_done = i_end & busy_q;
  assign o_fail = i_fail;
  assign o_lat  = cnt_q;

endmodule

// File: rtl/performance_way_latency_monitor.sv
// Purpose : per-way NAND op latency monitor; sums good-op latency and counts good/failed
//           ops over a window of i_cfg_thresh completions, then freezes with o_ready.
// Latency : completions visible one cycle after the end pulse; FULL/o_ready one cycle later.
// Backpressure: none; completions arriving in FULL or CLEAR are dropped.
// Ports: i_bus_clk, i_bus_rst_n (async active-low); mon_if (slave) carries the config,
// op pulses and result outputs. Define PERF_MINMAX_EN to track o_lat_max/o_lat_min;
// without it both outputs are tied to zero.
module performance_way_latency_monitor
  import performance_way_latency_monitor_pkg::*;
#(
  parameter int WAY    = DEF_WAY,
  parameter int LAT_WD = DEF_LAT_WD,
  parameter int REQ_WD = DEF_REQ_WD,
  parameter int SUM_WD = DEF_SUM_WD
) (
  input  logic                                   i_bus_clk,
  input  logic                                   i_bus_rst_n,
  performance_way_latency_monitor_if.slave       mon_if
);

  // Enough headroom to add WAY latencies to a full sum without overflow.
  localparam int CNT_WD = $clog2(WAY + 1);
  localparam int ACC_WD = SUM_WD + CNT_WD + 1;

  logic [WAY-1:0]    way_done;
  logic [WAY-1:0]    way_fail;
  logic [LAT_WD-1:0] way_lat [WAY];

  for (genvar w = 0; w < WAY; w++) begin : g_way
    performance_way_latency_monitor_timer #(.LAT_WD(LAT_WD)) u_timer (
      .i_bus_clk   (i_bus_clk),
      .i_bus_rst_n (i_bus_rst_n),
      .i_start     (mon_if.i_op_start[w]),
      .i_end       (mon_if.i_op_end[w]),
      .i_fail      (mon_if.i_op_fail[w]),
      .o_done      (way_done[w]),
      .o_fail      (way_fail[w]),
      .o_lat       (way_lat[w])
    );
  end

  perf_state_e       state_q;
  logic              ready_q;
  logic [SUM_WD-1:0] sum_q, sum_d;
  logic [REQ_WD-1:0] req_q, req_d;
  logic [REQ_WD-1:0] fail_q, fail_d;

  logic              accept;
  logic [CNT_WD-1:0] good_n;
  logic [CNT_WD-1:0] fail_n;
  logic [ACC_WD-1:0] lat_add;
  logic [ACC_WD-1:0] sum_ext;
  logic [REQ_WD:0]   req_ext;
  logic [REQ_WD:0]   fail_ext;

  assign accept = (state_q == ST_IDLE) || (state_q == ST_ACCUM);

  always_comb begin
    good_n  = '0;
    fail_n  = '0;
    lat_add = '0;
    for (int w = 0; w < WAY; w++) begin
      if (way_done[w]) begin
        if (way_fail[w]) begin
          fail_n = fail_n + 1'b1;
        end else begin
          good_n  = good_n + 1'b1;
          lat_add = lat_add + {{(ACC_WD-LAT_WD){1'b0}}, way_lat[w]};
        end
      end
    end
  end

  assign sum_ext  = {{(ACC_WD-SUM_WD){1'b0}}, sum_q} + lat_add;
  assign req_ext  = {1'b0, req_q}  + {{(REQ_WD+1-CNT_WD){1'b0}}, good_n};
  assign fail_ext = {1'b0, fail_q} + {{(REQ_WD+1-CNT_WD){1'b0}}, fail_n};

  always_comb begin
    sum_d  = sum_q;
    req_d  = req_q;
    fail_d = fail_q;
    if (mon_if.i_cp_cmplt) begin
      // Clear wins over any completion in the same cycle.
      sum_d  = '0;
      req_d  = '0;
      fail_d = '0;
    end else if (accept) begin
      sum_d  = (|sum_ext[ACC_WD-1:SUM_WD]) ? {SUM_WD{1'b1}} : sum_ext[SUM_WD-1:0];
      req_d  = req_ext[REQ_WD]  ? {REQ_WD{1'b1}} : req_ext[REQ_WD-1:0];
      fail_d = fail_ext[REQ_WD] ? {REQ_WD{1'b1}} : fail_ext[REQ_WD-1:0];
    end
  end

  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      sum_q  <= '0;
      req_q  <= '0;
      fail_q <= '0;
    end else begin
      sum_q  <= sum_d;
      req_q  <= req_d;
      fail_q <= fail_d;
    end
  end

  // Window FSM; o_ready is set on the edge that enters FULL so it is high in
  // FULL's first cycle. The datapath above already clears on i_cp_cmplt, so the
  // CLEAR cycle shows reset values.
  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else if (mon_if.i_cp_cmplt) begin
      state_q <= ST_CLEAR;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|mon_if.i_op_start) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if ((mon_if.i_cfg_thresh != '0) && (req_q >= mon_if.i_cfg_thresh)) begin
            state_q <= ST_FULL;
            ready_q <= 1'b1;
          end
        end
        ST_FULL: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon_if.o_lat_sum  = sum_q;
  assign mon_if.o_req_cnt  = req_q;
  assign mon_if.o_fail_cnt = fail_q;
  assign mon_if.o_ready    = ready_q;

`ifdef PERF_MINMAX_EN
  logic [LAT_WD-1:0] max_q, max_d;
  logic [LAT_WD-1:0] min_q, min_d;
  logic [LAT_WD-1:0] cyc_max, cyc_min;

  // Max/min across this cycle's good completions, then merged with the window.
  always_comb begin
    cyc_max = '0;
    cyc_min = {LAT_WD{1'b1}};
    for (int w = 0; w < WAY; w++) begin
      if (way_done[w] && !way_fail[w]) begin
        if (way_lat[w] > cyc_max) cyc_max = way_lat[w];
        if (way_lat[w] < cyc_min) cyc_min = way_lat[w];
      end
    end
  end

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (mon_if.i_cp_cmplt) begin
      max_d = '0;
      min_d = {LAT_WD{1'b1}};
    end else if (accept) begin
      if (cyc_max > max_q) max_d = cyc_max;
      if (cyc_min < min_q) min_d = cyc_min;
    end
  end

  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      max_q <= '0;
      min_q <= {LAT_WD{1'b1}};
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign mon_if.o_lat_max = max_q;
  assign mon_if.o_lat_min = min_q;
`else
  assign mon_if.o_lat_max = '0;
  assign mon_if.o_lat_min = '0;
`endif

endmodule

// File: tb/tb_performance_way_latency_monitor.sv
// Directed bench for the per-way latency monitor. LAT_WD is reduced to 8 so the
// saturating-latency case fits in a few hundred cycles.
module tb_performance_way_latency_monitor;

  localparam int WAY    = 4;
  localparam int LAT_WD = 8;
  localparam int REQ_WD = 12;
  localparam int SUM_WD = 32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  performance_way_latency_monitor_if #(
    .WAY(WAY), .LAT_WD(LAT_WD), .REQ_WD(REQ_WD), .SUM_WD(SUM_WD)
  ) bus ();

  performance_way_latency_monitor #(
    .WAY(WAY), .LAT_WD(LAT_WD), .REQ_WD(REQ_WD), .SUM_WD(SUM_WD)
  ) dut (
    .i_bus_clk   (clk),
    .i_bus_rst_n (rst_n),
    .mon_if      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one cycle of op pulses; on return the edge that sampled them has passed.
  task automatic pulse(input logic [WAY-1:0] st, input logic [WAY-1:0] en,
                       input logic [WAY-1:0] fl, input logic cp);
    bus.i_op_start = st;
    bus.i_op_end   = en;
    bus.i_op_fail  = fl;
    bus.i_cp_cmplt = cp;
    step(1);
    bus.i_op_start = '0;
    bus.i_op_end   = '0;
    bus.i_op_fail  = '0;
    bus.i_cp_cmplt = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int sum, input int req, input int fl,
                         input int rdy);
    chk({tag, "_sum"},   64'(bus.o_lat_sum),  64'(sum));
    chk({tag, "_req"},   64'(bus.o_req_cnt),  64'(req));
    chk({tag, "_fail"},  64'(bus.o_fail_cnt), 64'(fl));
    chk({tag, "_ready"}, 64'(bus.o_ready),    64'(rdy));
  endtask

  task automatic chk_mm(input string tag, input int mx, input int mn);
`ifdef PERF_MINMAX_EN
    chk({tag, "_max"}, 64'(bus.o_lat_max), 64'(mx));
    chk({tag, "_min"}, 64'(bus.o_lat_min), 64'(mn));
`else
    chk({tag, "_max_tie"}, 64'(bus.o_lat_max), 64'(0));
    chk({tag, "_min_tie"}, 64'(bus.o_lat_min), 64'(0));
    if (mx < 0 || mn < 0) $display("note: negative min/max expectation in %s", tag);
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.i_cfg_thresh = '0;
    bus.i_cp_cmplt   = 1'b0;
    bus.i_op_start   = '0;
    bus.i_op_end     = '0;
    bus.i_op_fail    = '0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state
    chk_out("reset", 0, 0, 0, 0);
    chk_mm("reset", 0, 255);

    // 1: single op on way0, latency 100
    pulse(4'b0001, 4'b0000, 4'b0000, 1'b0);
    step(99);
    pulse(4'b0000, 4'b0001, 4'b0000, 1'b0);
    chk_out("single", 100, 1, 0, 0);
    chk_mm("single", 100, 100);

    // 2: way3 runs 70, way1 runs 50, both end together
    pulse(4'b1000, 4'b0000, 4'b0000, 1'b0);
    step(19);
    pulse(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(49);
    pulse(4'b0000, 4'b1010, 4'b0000, 1'b0);
    chk_out("overlap", 220, 3, 0, 0);
    chk_mm("overlap", 100, 50);

    // 4: failed op on way2, then an end on idle way0
    pulse(4'b0100, 4'b0000, 4'b0000, 1'b0);
    step(9);
    pulse(4'b0000, 4'b0100, 4'b0100, 1'b0);
    chk_out("fail", 220, 3, 1, 0);
    pulse(4'b0000, 4'b0001, 4'b0000, 1'b0);
    chk_out("idle_end", 220, 3, 1, 0);

    // Clear outside FULL
    pulse(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk_out("clear1", 0, 0, 0, 0);
    chk_mm("clear1", 0, 255);
    step(1);

    // 3: threshold 3; two ops of 10, then four ops of 5 step req from 2 to 6
    bus.i_cfg_thresh = 12'd3;
    pulse(4'b0011, 4'b0000, 4'b0000, 1'b0);
    step(9);
    pulse(4'b0000, 4'b0011, 4'b0000, 1'b0);
    chk_out("thr_pre", 20, 2, 0, 0);
    pulse(4'b1111, 4'b0000, 4'b0000, 1'b0);
    step(4);
    pulse(4'b0000, 4'b1111, 4'b0000, 1'b0);
    chk_out("thr_step", 40, 6, 0, 0);
    chk_mm("thr_step", 10, 5);
    step(1);
    chk_out("thr_full", 40, 6, 0, 1);
    // Completions while FULL are discarded
    pulse(4'b0001, 4'b0000, 4'b0000, 1'b0);
    step(2);
    pulse(4'b0000, 4'b0001, 4'b0000, 1'b0);
    pulse(4'b0010, 4'b0000, 4'b0000, 1'b0);
    pulse(4'b0000, 4'b0010, 4'b0010, 1'b0);
    chk_out("frozen", 40, 6, 0, 1);
    chk_mm("frozen", 10, 5);

    // 5: timer on way3 started in FULL survives the clear (latency 30)
    pulse(4'b1000, 4'b0000, 4'b0000, 1'b0);
    step(4);
    pulse(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk_out("clear2", 0, 0, 0, 0);
    step(1);
    chk_out("clear2_idle", 0, 0, 0, 0);
    step(23);
    pulse(4'b0000, 4'b1000, 4'b0000, 1'b0);
    chk_out("post_clear", 30, 1, 0, 0);
    chk_mm("post_clear", 30, 30);
    // Copy-done coincident with a completion: the completion is lost
    pulse(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4);
    pulse(4'b0000, 4'b0010, 4'b0000, 1'b1);
    chk_out("clear_wins", 0, 0, 0, 0);
    step(2);
    chk_out("clear_wins_after", 0, 0, 0, 0);

    // 6: saturating latency, 2^8+5 = 261 cycles reports 255
    bus.i_cfg_thresh = '0;
    pulse(4'b0001, 4'b0000, 4'b0000, 1'b0);
    step(260);
    pulse(4'b0000, 4'b0001, 4'b0000, 1'b0);
    chk_out("lat_sat", 255, 1, 0, 0);
    chk_mm("lat_sat", 255, 255);

    // Asynchronous reset mid-op; later end is ignored
    pulse(4'b0100, 4'b0000, 4'b0000, 1'b0);
    step(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    chk_mm("async_rst", 0, 255);
    step(1);
    rst_n = 1'b1;
    step(1);
    pulse(4'b0000, 4'b0100, 4'b0000, 1'b0);
    chk_out("rst_end_ignored", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
